fetch_pc_ctrl: RTL and testbench

//  Owns the fetch PC register and sequences instruction fetch over the ibus request/data_ok handshake.

---
 rtl/fetch_pc_ctrl_pkg.sv | 29 ++
 rtl/fetch_pc_ctrl_if.sv | 29 ++
 rtl/fetch_pc_ctrl.sv | 124 ++++++++++++
 tb/tb_fetch_pc_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared types and constants for the fetch PC controller.
//   u64 / u32       : plain unsigned vector typedefs
//   PC_RESET        : default first fetch address after reset
//   PCSelectType    : select code driven into the fetch PC mux
//   fetch_state_t   : fetch sequencer states
package fetch_pc_ctrl_pkg;

    typedef logic [63:0] u64;
    typedef logic [31:0] u32;

    localparam u64 PC_RESET = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        NoNewPC         = 2'd0,
        PC_From_add4    = 2'd1,
        PC_From_add_imm = 2'd2,
        PC_From_jalr    = 2'd3
    } PCSelectType;

    // S_REQ  : request outstanding, result will be kept
    // S_HOLD : instruction held for decode, no request
    // S_DROP : request outstanding, result is stale and will be discarded
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Instruction bus between the fetch PC controller (master) and the
// instruction memory side (slave).
//   ireq_valid : fetch request valid
//   ireq_addr  : fetch address, held until iresp_ok
//   iresp_ok   : one-cycle pulse completing the outstanding request
//   iresp_data : instruction word, valid with iresp_ok
interface fetch_pc_ctrl_if;
    import fetch_pc_ctrl_pkg::*;

    logic ireq_valid;
    u64   ireq_addr;
    logic iresp_ok;
    u32   iresp_data;

    modport master (
        output ireq_valid,
        output ireq_addr,
        input  iresp_ok,
        input  iresp_data
    );

    modport slave (
        input  ireq_valid,
        input  ireq_addr,
        output iresp_ok,
        output iresp_data
    );

endinterface

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC controller: owns the fetch PC, issues one ibus request at a time,
// hands each returned instruction to decode over if_valid/if_ready, and
// absorbs execute redirects that arrive while a request is in flight (the
// in-flight fetch completes and its data is discarded and counted).
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   ibus         : instruction bus master (request/data_ok handshake)
//   if_valid/if_pc/if_instr/if_ready : held instruction to decode
//   redir_valid/redir_sel : taken control transfer from execute
//   pc_select/pcplus4/pc_nxt : loop through the external fetch PC mux
//   drop_cnt     : count of fetched-then-discarded instructions (wraps)
module fetch_pc_ctrl
    import fetch_pc_ctrl_pkg::*;
#(
    parameter u64          RESET_PC = PC_RESET,
    parameter int unsigned CNT_W    = 32
) (
    input  logic               clk,
    input  logic               reset,
    fetch_pc_ctrl_if.master    ibus,
    output logic               if_valid,
    output u64                 if_pc,
    output u32                 if_instr,
    input  logic               if_ready,
    input  logic               redir_valid,
    input  PCSelectType        redir_sel,
    output PCSelectType        pc_select,
    output u64                 pcplus4,
    input  u64                 pc_nxt,
    output logic [CNT_W-1:0]   drop_cnt
);

    fetch_state_t      state_q, state_d;
    u64                pc_q, pc_d;
    u64                pend_q, pend_d;
    u32                instr_q, instr_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic              advance;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
            instr_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            instr_q <= instr_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        instr_d = instr_q;
        drop_d  = drop_q;

        // A redirect always wins over decode accepting the held instruction.
        advance = (state_q == S_HOLD) && if_ready && !redir_valid && !reset;

        unique case (state_q)
            S_REQ: begin
                if (ibus.iresp_ok && redir_valid) begin
                    pc_d   = pc_nxt;
                    drop_d = drop_q + CNT_W'(1);
                end else if (ibus.iresp_ok) begin
                    instr_d = ibus.iresp_data;
                    state_d = S_HOLD;
                end else if (redir_valid) begin
                    pend_d  = pc_nxt;
                    state_d = S_DROP;
                end
            end
            S_HOLD: begin
                // iresp_ok here is a protocol violation and is ignored.
                if (redir_valid) begin
                    pc_d    = pc_nxt;
                    drop_d  = drop_q + CNT_W'(1);
                    state_d = S_REQ;
                end else if (if_ready) begin
                    pc_d    = pc_nxt;
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (redir_valid) begin
                    pend_d = pc_nxt;
                end
                if (ibus.iresp_ok) begin
                    // A redirect coincident with the stale completion is
                    // newer than anything parked in pend_q.
                    pc_d    = redir_valid ? pc_nxt : pend_q;
                    drop_d  = drop_q + CNT_W'(1);
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        if (redir_valid) begin
            pc_select = redir_sel;
        end else if (advance) begin
            pc_select = PC_From_add4;
        end else begin
            pc_select = NoNewPC;
        end
    end

    assign ibus.ireq_valid = (state_q != S_HOLD) && !reset;
    assign ibus.ireq_addr  = pc_q;
    assign if_valid        = (state_q == S_HOLD) && !reset;
    assign if_pc           = pc_q;
    assign if_instr        = instr_q;
    assign pcplus4         = pc_q + 64'd4;
    assign drop_cnt        = drop_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
module tb_fetch_pc_ctrl;
    import fetch_pc_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_valid;
    u64          if_pc;
    u32          if_instr;
    logic        if_ready = 1'b0;
    logic        redir_valid = 1'b0;
    PCSelectType redir_sel = NoNewPC;
    PCSelectType pc_select;
    u64          pcplus4;
    u64          pc_nxt = '0;
    logic [31:0] drop_cnt;

    fetch_pc_ctrl_if ibus();

    fetch_pc_ctrl #(.RESET_PC(64'h0000_0000_8000_0000), .CNT_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .ibus       (ibus.master),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_instr   (if_instr),
        .if_ready   (if_ready),
        .redir_valid(redir_valid),
        .redir_sel  (redir_sel),
        .pc_select  (pc_select),
        .pcplus4    (pcplus4),
        .pc_nxt     (pc_nxt),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: what fetch has in hand, expressed as flags.
    u64          m_pc = 64'h0;
    u64          m_pend = 64'h0;
    u32          m_instr = 32'h0;
    logic [31:0] m_drops = 32'h0;
    bit          m_held = 1'b0;   // instruction waiting for decode
    bit          m_stale = 1'b0;  // outstanding fetch will be thrown away

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_pc <= 64'h0000_0000_8000_0000;
            m_pend <= '0;
            m_instr <= '0;
            m_drops <= '0;
            m_held <= 1'b0;
            m_stale <= 1'b0;
        end else if (m_held) begin
            if (redir_valid) begin
                m_pc <= pc_nxt;
                m_drops <= m_drops + 1;
                m_held <= 1'b0;
            end else if (if_ready) begin
                m_pc <= m_pc + 64'd4;
                m_held <= 1'b0;
            end
        end else begin
            if (ibus.iresp_ok) begin
                if (redir_valid)  m_pc <= pc_nxt;
                else if (m_stale) m_pc <= m_pend;
                if (m_stale || redir_valid) m_drops <= m_drops + 1;
                else begin
                    m_instr <= ibus.iresp_data;
                    m_held <= 1'b1;
                end
                m_stale <= 1'b0;
            end else if (redir_valid) begin
                m_pend <= pc_nxt;
                m_stale <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ireq_valid", 64'(ibus.ireq_valid), 64'(!reset && !m_held));
            chk("if_valid", 64'(if_valid), 64'(!reset && m_held));
            chk("drop_cnt", 64'(drop_cnt), 64'(m_drops));
            chk("pcplus4", pcplus4, m_pc + 64'd4);
            if (!reset) begin
                chk("ireq_addr", ibus.ireq_addr, m_pc);
                chk("pc_select", 64'(pc_select),
                    redir_valid ? 64'(redir_sel) :
                    ((m_held && if_ready) ? 64'(PC_From_add4) : 64'(NoNewPC)));
                if (m_held) begin
                    chk("if_pc", if_pc, m_pc);
                    chk("if_instr", 64'(if_instr), 64'(m_instr));
                end
            end
        end
    end

    // Apply one cycle of inputs; returns at the following negedge.
    // pc_nxt plays the external PC mux: redirect target or pc+4.
    task automatic step(input bit r, input bit ok, input u32 data, input bit rdy,
                        input bit rv, input PCSelectType sel, input u64 tgt);
        @(posedge clk);
        #1;
        reset = r;
        ibus.iresp_ok = ok;
        ibus.iresp_data = data;
        if_ready = rdy;
        redir_valid = rv;
        redir_sel = rv ? sel : NoNewPC;
        pc_nxt = rv ? tgt : m_pc + 64'd4;
        chk_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 32'h0, 0, 0, NoNewPC, 64'h0);
    endtask

    initial begin
        ibus.iresp_ok = 1'b0;
        ibus.iresp_data = '0;
        for (int i = 0; i < 3; i++) step(1, 0, 32'h0, 0, 0, NoNewPC, 64'h0);
        chk("lit_rst_ireq_valid", 64'(ibus.ireq_valid), 64'd0);
        chk("lit_rst_if_valid", 64'(if_valid), 64'd0);

        idle(1);
        chk("lit_first_valid", 64'(ibus.ireq_valid), 64'd1);
        chk("lit_first_addr", ibus.ireq_addr, 64'h8000_0000);
        chk("lit_first_drop", 64'(drop_cnt), 64'd0);

        idle(1);
        step(0, 1, 32'h0000_0013, 0, 0, NoNewPC, 64'h0);
        step(0, 0, 32'h0, 1, 0, NoNewPC, 64'h0);
        chk("lit_hold_valid", 64'(if_valid), 64'd1);
        chk("lit_hold_instr", 64'(if_instr), 64'h13);
        chk("lit_hold_sel", 64'(pc_select), 64'(PC_From_add4));
        idle(1);
        chk("lit_next_addr", ibus.ireq_addr, 64'h8000_0004);
        chk("lit_next_ifv", 64'(if_valid), 64'd0);

        step(0, 1, 32'h0010_0093, 0, 0, NoNewPC, 64'h0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 32'h0, 0, 0, NoNewPC, 64'h0);
            chk("lit_stall_pc", if_pc, 64'h8000_0004);
            chk("lit_stall_instr", 64'(if_instr), 64'h0010_0093);
            chk("lit_stall_req", 64'(ibus.ireq_valid), 64'd0);
            chk("lit_stall_sel", 64'(pc_select), 64'(NoNewPC));
        end
        step(0, 0, 32'h0, 1, 0, NoNewPC, 64'h0);

        step(0, 0, 32'h0, 0, 1, PC_From_add_imm, 64'h8000_0100);
        chk("lit_redir_sel", 64'(pc_select), 64'(PC_From_add_imm));
        chk("lit_redir_addr", ibus.ireq_addr, 64'h8000_0008);
        idle(2);
        step(0, 1, 32'hdead_beef, 0, 0, NoNewPC, 64'h0);
        chk("lit_stale_addr", ibus.ireq_addr, 64'h8000_0008);
        idle(1);
        chk("lit_drop_addr", ibus.ireq_addr, 64'h8000_0100);
        chk("lit_drop_ifv", 64'(if_valid), 64'd0);
        chk("lit_drop_cnt1", 64'(drop_cnt), 64'd1);

        step(0, 0, 32'h0, 0, 1, PC_From_jalr, 64'h8000_0300);
        step(0, 0, 32'h0, 0, 1, PC_From_add_imm, 64'h8000_0100);
        step(0, 0, 32'h0, 0, 1, PC_From_add_imm, 64'h8000_0200);
        step(0, 1, 32'h1111_1111, 0, 0, NoNewPC, 64'h0);
        idle(1);
        chk("lit_latest_wins", ibus.ireq_addr, 64'h8000_0200);
        chk("lit_drop_cnt2", 64'(drop_cnt), 64'd2);
        step(0, 1, 32'h2222_2222, 0, 1, PC_From_jalr, 64'h8000_0400);
        chk("lit_coinc_ifv", 64'(if_valid), 64'd0);
        idle(1);
        chk("lit_coinc_addr", ibus.ireq_addr, 64'h8000_0400);
        chk("lit_drop_cnt3", 64'(drop_cnt), 64'd3);
        chk("lit_coinc_ifv2", 64'(if_valid), 64'd0);

        step(0, 1, 32'h3333_3333, 0, 0, NoNewPC, 64'h0);
        step(0, 0, 32'h0, 1, 1, PC_From_jalr, 64'h8000_0800);
        chk("lit_rb_ifv", 64'(if_valid), 64'd1);
        chk("lit_rb_sel", 64'(pc_select), 64'(PC_From_jalr));
        idle(1);
        chk("lit_rb_addr", ibus.ireq_addr, 64'h8000_0800);
        chk("lit_rb_drop", 64'(drop_cnt), 64'd4);
        chk("lit_rb_ifv2", 64'(if_valid), 64'd0);
        step(0, 0, 32'h0, 0, 1, PC_From_add_imm, 64'h8000_0900);
        step(1, 0, 32'h0, 0, 0, NoNewPC, 64'h0);
        idle(1);
        chk("lit_rst_drop_addr", ibus.ireq_addr, 64'h8000_0000);
        chk("lit_rst_drop_cnt", 64'(drop_cnt), 64'd0);

        for (int i = 0; i < 3000; i++) begin
            bit r, ok, rdy, rv;
            PCSelectType sel;
            u64 tgt;
            r   = ($urandom_range(0, 149) == 0);
            ok  = m_held ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 2) == 0);
            rdy = $urandom_range(0, 1) == 1;
            rv  = ($urandom_range(0, 5) == 0);
            sel = $urandom_range(0, 1) == 1 ? PC_From_jalr : PC_From_add_imm;
            tgt = {$urandom(), $urandom()} & ~64'h3;
            if (i == 1500) tgt = 64'hFFFF_FFFF_FFFF_FFFC;
            step(r, ok, $urandom(), rdy, rv, sel, tgt);
        end

        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
